// File: rtl/riscv_multicycle_hs.sv
// rtl/riscv_multicycle_hs.sv - multicycle RV32I-subset core on a single req/ack memory port
//
// Ports:
//   clk, reset                         clock; asynchronous active-high reset
//   mem_req, mem_we, mem_addr,         registered request; held stable until mem_ack
//   mem_wdata
//   mem_rdata, mem_ack                 read data and completion strobe from memory
//   halted, illegal, misaligned        sticky stop flag and its cause
//   instret                            retired-instruction count, wraps
module riscv_multicycle_hs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             halted,
    output logic             illegal,
    output logic             misaligned,
    output logic [CNT_W-1:0] instret
);
    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_BRANCH, S_JUMP, S_UPPER, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
    } alu_op_t;

    state_t      state;
    logic [31:0] pc, old_pc, ir, a, b, imm, alu_out, mdr;
    logic [31:0] regs [NREGS];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    function automatic logic reg_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                          input alu_op_t op);
        case (op)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_XOR: return x ^ y;
            ALU_SLT: return {31'b0, $signed(x) < $signed(y)};
            default: return x + y;
        endcase
    endfunction

    // Decode is combinational off IR; it is only consumed in DECODE and later states,
    // where IR is stable for the whole instruction.
    logic [31:0] imm_d, rf_a, rf_b;
    state_t      dispatch;
    logic        dec_ok, f3_alu_ok;
    alu_op_t     alu_op;

    always_comb begin
        imm_d     = 32'h0;
        dispatch  = S_HALT;
        dec_ok    = 1'b0;
        alu_op    = ALU_ADD;
        f3_alu_ok = funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
        case (opcode)
            OP_R: begin
                dispatch = S_EXECR;
                dec_ok   = ((funct7 == 7'b0000000 && f3_alu_ok) ||
                            (funct7 == 7'b0100000 && funct3 == 3'b000)) &&
                           reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_I: begin
                dispatch = S_EXECI;
                imm_d    = {{20{ir[31]}}, ir[31:20]};
                dec_ok   = f3_alu_ok && reg_ok(rd) && reg_ok(rs1);
            end
            OP_LW: begin
                dispatch = S_MEMADR;
                imm_d    = {{20{ir[31]}}, ir[31:20]};
                dec_ok   = funct3 == 3'b010 && reg_ok(rd) && reg_ok(rs1);
            end
            OP_SW: begin
                dispatch = S_MEMADR;
                imm_d    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                dec_ok   = funct3 == 3'b010 && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_BR: begin
                dispatch = S_BRANCH;
                imm_d    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                dec_ok   = funct3[2:1] == 2'b00 && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_JAL: begin
                dispatch = S_JUMP;
                imm_d    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                dec_ok   = reg_ok(rd);
            end
            OP_JALR: begin
                dispatch = S_JUMP;
                imm_d    = {{20{ir[31]}}, ir[31:20]};
                dec_ok   = funct3 == 3'b000 && reg_ok(rd) && reg_ok(rs1);
            end
            OP_LUI, OP_AUIPC: begin
                dispatch = S_UPPER;
                imm_d    = {ir[31:12], 12'b0};
                dec_ok   = reg_ok(rd);
            end
            default: dec_ok = 1'b0;
        endcase
        rf_a = reg_ok(rs1) ? regs[rs1[RIDX_W-1:0]] : 32'h0;
        rf_b = reg_ok(rs2) ? regs[rs2[RIDX_W-1:0]] : 32'h0;
    end

    // Retire, write-back and next-PC selection for every state that ends an instruction.
    logic        br_taken, retire, wb_en;
    logic [31:0] br_target, jmp_target, mem_ea, next_pc, wb_data;

    always_comb begin
        br_taken   = (a == b) ^ funct3[0];
        br_target  = old_pc + imm;
        jmp_target = (opcode == OP_JAL) ? old_pc + imm : ((a + imm) & ~32'd1);
        mem_ea     = a + imm;
        next_pc    = pc;
        wb_data    = 32'h0;
        retire     = 1'b0;
        wb_en      = 1'b0;
        case (state)
            S_ALUWB: begin
                retire  = 1'b1;
                wb_en   = 1'b1;
                wb_data = alu_out;
            end
            S_MEMWB: begin
                retire  = 1'b1;
                wb_en   = 1'b1;
                wb_data = mdr;
            end
            S_MEMWRITE: retire = mem_ack;
            S_BRANCH: begin
                // A taken branch to a non-word target halts instead of retiring.
                retire  = !(br_taken && br_target[1]);
                next_pc = br_taken ? br_target : pc;
            end
            S_JUMP: begin
                retire  = !jmp_target[1];
                wb_en   = 1'b1;
                wb_data = old_pc + 32'd4;
                next_pc = jmp_target;
            end
            S_UPPER: begin
                retire  = 1'b1;
                wb_en   = 1'b1;
                wb_data = (opcode == OP_LUI) ? imm : old_pc + imm;
            end
            default: retire = 1'b0;
        endcase
        wb_en = wb_en && retire && (rd != 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            old_pc     <= 32'h0;
            ir         <= 32'h0;
            a          <= 32'h0;
            b          <= 32'h0;
            imm        <= 32'h0;
            alu_out    <= 32'h0;
            mdr        <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            misaligned <= 1'b0;
            instret    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
        end else begin
            if (wb_en) regs[rd[RIDX_W-1:0]] <= wb_data;
            case (state)
                S_FETCH: begin
                    // Only the fetch right after reset arrives here without a request.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir      <= mem_rdata;
                        old_pc  <= pc;
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a   <= rf_a;
                    b   <= rf_b;
                    imm <= imm_d;
                    if (dec_ok) begin
                        state <= dispatch;
                    end else begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end
                end
                S_EXECR: begin
                    alu_out <= alu_f(a, b, alu_op);
                    state   <= S_ALUWB;
                end
                S_EXECI: begin
                    alu_out <= alu_f(a, imm, alu_op);
                    state   <= S_ALUWB;
                end
                S_MEMADR: begin
                    if (mem_ea[1:0] != 2'b00) begin
                        state      <= S_HALT;
                        halted     <= 1'b1;
                        misaligned <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= mem_ea;
                        mem_we   <= (opcode == OP_SW);
                        if (opcode == OP_SW) mem_wdata <= b;
                        state    <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    if (mem_ack) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_MEMWB;
                    end
                end
                S_BRANCH, S_JUMP: begin
                    if (!retire) begin
                        state      <= S_HALT;
                        halted     <= 1'b1;
                        misaligned <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Retiring launches the next fetch on the same edge so FETCH starts with req high.
            if (retire) begin
                instret  <= instret + 1'b1;
                pc       <= next_pc;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= next_pc;
                state    <= S_FETCH;
            end
        end
    end
endmodule

// File: tb/tb_riscv_multicycle_hs.sv
// tb/tb_riscv_multicycle_hs.sv - directed self-checking bench for riscv_multicycle_hs
module tb_riscv_multicycle_hs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted, illegal, misaligned;
    logic [31:0] mem_addr, mem_wdata, instret;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    riscv_multicycle_hs #(.RESET_PC(32'h0000_0000), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .halted(halted), .illegal(illegal),
        .misaligned(misaligned), .instret(instret)
    );

    logic [31:0] prog [256];
    logic [31:0] dmem [int];
    logic [31:0] st_addr[$], st_data[$], st_ret[$], st_cyc[$], fa[$];
    int          checks = 0, errors = 0;
    int          max_wait = 0, wait_left = 0, cyc = 0, halt_reqs = 0;
    logic        stall_en = 1'b0;
    logic [31:0] stall_addr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        int i = int'(addr[9:2]);
        if (dmem.exists(i)) return dmem[i];
        return prog[i];
    endfunction

    // Memory response: decided on the falling edge, consumed on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            mem_ack   = 1'b0;
            wait_left = 0;
        end else begin
            if (mem_ack) wait_left = (max_wait > 0) ? int'($urandom_range(max_wait)) : 0;
            if (!mem_req || (stall_en && mem_addr == stall_addr)) begin
                mem_ack = 1'b0;
            end else if (wait_left > 0) begin
                mem_ack = 1'b0;
                wait_left--;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = rd_word(mem_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            cyc       = 0;
            halt_reqs = 0;
            dmem.delete();
            st_addr.delete();
            st_data.delete();
            st_ret.delete();
            st_cyc.delete();
            fa.delete();
        end else begin
            cyc++;
            if (halted && mem_req) halt_reqs++;
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    dmem[int'(mem_addr[9:2])] = mem_wdata;
                    st_addr.push_back(mem_addr);
                    st_data.push_back(mem_wdata);
                    st_ret.push_back(instret);
                    st_cyc.push_back(cyc);
                end else begin
                    fa.push_back(mem_addr);
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int nst, input int budget, input string tag);
        int n = 0;
        while (st_addr.size() < nst && !halted && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic load_rvtest();
        clear_prog();
        prog[0]  = 32'h00500113; prog[1]  = 32'h00C00193; prog[2]  = 32'hFF718393;
        prog[3]  = 32'h0023E233; prog[4]  = 32'h0041F2B3; prog[5]  = 32'h004282B3;
        prog[6]  = 32'h02728863; prog[7]  = 32'h0041A233; prog[8]  = 32'h00020463;
        prog[9]  = 32'h00000293; prog[10] = 32'h0023A233; prog[11] = 32'h005203B3;
        prog[12] = 32'h402383B3; prog[13] = 32'h0471AA23; prog[14] = 32'h06002103;
        prog[15] = 32'h005104B3; prog[16] = 32'h008001EF; prog[17] = 32'h00100113;
        prog[18] = 32'h00910133; prog[19] = 32'h0221A023; prog[20] = 32'h00210063;
    endtask

    initial begin
        clear_prog();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_misal", 32'(misaligned), 32'd0);
        check("rst_instret", instret, 32'd0);

        // Reference program, zero-wait memory.
        load_rvtest();
        max_wait = 0;
        do_reset();
        @(posedge clk);
        #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'd0);
        run(2, 1000, "t1_budget");
        check("t1_a0", q_at(st_addr, 0), 32'd96);
        check("t1_d0", q_at(st_data, 0), 32'd7);
        check("t1_a1", q_at(st_addr, 1), 32'd100);
        check("t1_d1", q_at(st_data, 1), 32'd25);
        check("t1_ret0", q_at(st_ret, 0), 32'd12);
        check("t1_ret1", q_at(st_ret, 1), 32'd17);
        check("t1_cyc0", q_at(st_cyc, 0), 32'd51);
        check("t1_cyc1", q_at(st_cyc, 1), 32'd71);

        // Same program with 0-3 wait states per request.
        max_wait = 3;
        do_reset();
        run(2, 4000, "t2_budget");
        check("t2_a0", q_at(st_addr, 0), 32'd96);
        check("t2_d0", q_at(st_data, 0), 32'd7);
        check("t2_a1", q_at(st_addr, 1), 32'd100);
        check("t2_d1", q_at(st_data, 1), 32'd25);
        check("t2_ret1", q_at(st_ret, 1), 32'd17);
        check("t2_halted", 32'(halted), 32'd0);
        max_wait = 0;

        // lui / auipc / bne, then an illegal opcode.
        clear_prog();
        prog[0] = 32'h123452B7; prog[1] = 32'h00000013; prog[2] = 32'h00000013;
        prog[3] = 32'h00000013; prog[4] = 32'h00001317; prog[5] = 32'h00000013;
        prog[6] = 32'h00629463; prog[7] = 32'h00002423; prog[8] = 32'h00502023;
        prog[9] = 32'h00602223; prog[10] = 32'h0000007F;
        do_reset();
        run(99, 500, "t3_budget");
        check("t3_nst", st_addr.size(), 32'd2);
        check("t3_x5", q_at(st_data, 0), 32'h12345000);
        check("t3_x6", q_at(st_data, 1), 32'h00001010);
        check("t3_a1", q_at(st_addr, 1), 32'd4);
        check("t3_fetch", q_at(fa, 7), 32'h20);
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_illegal", 32'(illegal), 32'd1);
        check("t3_misal", 32'(misaligned), 32'd0);
        check("t3_instret", instret, 32'd9);

        // Writes to x0 are discarded.
        clear_prog();
        prog[0] = 32'h00500013; prog[1] = 32'h00002023; prog[2] = 32'h0000007F;
        do_reset();
        run(99, 500, "t4_budget");
        check("t4_nst", st_addr.size(), 32'd1);
        check("t4_addr", q_at(st_addr, 0), 32'd0);
        check("t4_x0", q_at(st_data, 0), 32'd0);
        check("t4_instret", instret, 32'd2);

        // Misaligned load halts without retiring or issuing more requests.
        clear_prog();
        prog[0] = 32'h00000013; prog[1] = 32'h00202083;
        do_reset();
        run(99, 500, "t5_budget");
        repeat (20) @(posedge clk);
        #1;
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_misal", 32'(misaligned), 32'd1);
        check("t5_illegal", 32'(illegal), 32'd0);
        check("t5_instret", instret, 32'd1);
        check("t5_halt_reqs", halt_reqs, 32'd0);
        check("t5_req", 32'(mem_req), 32'd0);

        // Reset while a fetch waits for mem_ack.
        clear_prog();
        prog[0] = 32'h00000013; prog[1] = 32'h00000013; prog[2] = 32'h00000013;
        prog[3] = 32'h00500013; prog[4] = 32'h00002023; prog[5] = 32'h0000007F;
        stall_en   = 1'b1;
        stall_addr = 32'h8;
        do_reset();
        repeat (40) @(posedge clk);
        #2;
        check("t6_wait_req", 32'(mem_req), 32'd1);
        check("t6_wait_addr", mem_addr, 32'h8);
        check("t6_wait_ret", instret, 32'd2);
        reset = 1'b1;
        #1;
        check("t6_async_req", 32'(mem_req), 32'd0);
        check("t6_async_addr", mem_addr, 32'd0);
        check("t6_async_ret", instret, 32'd0);
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(99, 500, "t6_budget");
        check("t6_fetch0", q_at(fa, 0), 32'h0);
        check("t6_nst", st_addr.size(), 32'd1);
        check("t6_instret", instret, 32'd5);
        check("t6_illegal", 32'(illegal), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_hs.md
Name: riscv_multicycle_hs

Overview:
- Parametrised multicycle RV32I-subset core, successor to the single-cycle core.
- Uses a single unified memory port (instruction + data) with a req/ack handshake that tolerates any number of wait states.
- Adds bne, lui, a retired-instruction counter, and sticky halt on illegal opcode or misaligned access.
- Sits in top in place of the single-cycle core plus split imem/dmem; connects to one memory wrapper.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E); illegal register index → illegal halt
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory request valid; held until mem_ack
mem_we  out  1  1 = store, 0 = read (fetch or load)
mem_addr  out  32  byte address, word aligned
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid in the mem_ack cycle
mem_ack  in  1  completes the current request; ignored when mem_req=0
halted  out  1  sticky; core stopped
illegal  out  1  sticky; halt cause is an illegal instruction
misaligned  out  1  sticky; halt cause is a misaligned lw/sw
instret  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async), all cleared immediately, including a request in flight:
  - PC=RESET_PC; state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - halted, illegal, misaligned=0; instret=0; all registers=0.
  - First request is issued in the first cycle after reset deasserts.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable while mem_req=1 and mem_ack=0.
  - A transfer completes on a clk edge with mem_req & mem_ack; mem_req drops the next cycle unless a new request starts.
  - Zero-wait ack (ack in the first req cycle) is legal.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: IR<=mem_rdata, OldPC<=PC, PC<=PC+4 → DECODE.
  - DECODE: read rs1/rs2 into A/B; ImmExt per type (I, S, B, J, U). Dispatch by opcode:
    - lw/sw → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - beq/bne → BRANCH
    - jal/jalr → JUMP
    - lui/auipc → UPPER
    - other → HALT with illegal=1
  - EXECR / EXECI: ALU op add, sub, and, or, xor, slt (ALU encoding as the existing core) → ALUWB.
  - ALUWB: rd<=ALUOut; retire → FETCH.
  - MEMADR: addr=A+ImmExt.
    - addr[1:0]≠0 → HALT with misaligned=1.
    - Otherwise lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: read request at addr; on ack capture data → MEMWB.
  - MEMWB: rd<=data; retire → FETCH.
  - MEMWRITE: mem_we=1, mem_wdata=B; on ack retire → FETCH.
  - BRANCH: taken if (A==B) XOR funct3[0]; if taken PC<=OldPC+ImmExt; retire → FETCH.
  - JUMP:
    - rd<=OldPC+4.
    - jal: PC<=OldPC+ImmExt.
    - jalr: PC<=(A+ImmExt) & ~1.
    - Retire → FETCH.
  - UPPER: rd<=ImmExt (lui) or OldPC+ImmExt (auipc); retire → FETCH.
  - HALT: no requests, no state change until reset.
- Cycle counts with zero-wait memory:
  - 3 cycles: branch, jal, jalr, lui, auipc.
  - 4 cycles: R, I, sw.
  - 5 cycles: lw.
  - Each memory wait cycle adds 1.
- Register file:
  - Writes to x0 are discarded; x0 always reads 0.
  - Write occurs on the retire edge; the next DECODE observes it.
- instret increments by 1 on each retire edge only (never in HALT or on an illegal instruction).
- Arithmetic: 32-bit, wrap-around; PC+4 wraps at 2^32.
- Instruction-fetch misalignment is impossible: the jalr LSB is cleared; branch/jal targets with bit1 set → HALT with misaligned=1.

Test Plan:
- Existing RV test program (addi/add/sub/and/or/slt/beq/lw/sw/jal) with zero-wait memory → store of 25 to address 100; no stores to any address other than 96/100 before it.
- Same program with 0–3 random wait states per request → identical store sequence; instret at the final store equals the zero-wait run.
- lui x5,0x12345; auipc x6,1 at PC=0x10; bne x5,x6,+8 → x5=0x12345000, x6=0x1010, branch taken, PC=0x20 next fetch.
- addi x0,x0,5 then sw x0,0(x0) → store of 0 to address 0; x0 stays 0.
- lw x1,2(x0) → halted=1, misaligned=1, no further mem_req, instret unchanged.
- Opcode 0x7F → halted=1, illegal=1.
- Assert reset while FETCH is waiting for mem_ack → mem_req=0 immediately; after release, fetch from RESET_PC.
